apu_irq_conditioner: RTL and testbench

// Conditions raw APU interrupt sources before they reach the PLIC int_src inputs.
// Per source: optional 2+ flop synchroniser, then one of two paths (selected by PULSE_MASK).

---
 rtl/apu_irq_conditioner.sv | 159 +++++++++++++++
 tb/tb_apu_irq_conditioner.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_irq_conditioner.sv
// Conditions raw APU interrupt sources into PLIC int_src levels/pulses; optional drop flags with APU_IRQ_COND_DROP_EN.
// Latency: SYNC_STAGES (async only) + max(FILTER_CYCLES,1) edges on level path, 1 edge on pulse path.
// No backpressure: a pulse source buffers one pending edge, further edges are dropped.
module apu_irq_conditioner #(
  parameter int               NUM_IRQ        = 63,
  parameter int               SYNC_STAGES    = 2,
  parameter int               FILTER_CYCLES  = 4,
  parameter int               STRETCH_CYCLES = 2,
  parameter logic [NUM_IRQ:1] ASYNC_MASK     = '0,
  parameter logic [NUM_IRQ:1] PULSE_MASK     = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ:1]   i_irq_raw,
  input  logic [NUM_IRQ:1]   i_irq_enable,
  output logic [NUM_IRQ:1]   o_irq
`ifdef APU_IRQ_COND_DROP_EN
  ,
  output logic [NUM_IRQ:1]   o_drop_sticky,
  input  logic [NUM_IRQ:1]   i_drop_clear
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STRETCH = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

  for (genvar g = 1; g <= NUM_IRQ; g++) begin : g_src
    logic samp;

    if (ASYNC_MASK[g]) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) chain <= '0;
        else          chain <= {chain[SYNC_STAGES-2:0], i_irq_raw[g]};
      end
      assign samp = chain[SYNC_STAGES-1] & i_irq_enable[g];
    end else begin : g_direct
      assign samp = i_irq_raw[g] & i_irq_enable[g];
    end

    if (!PULSE_MASK[g]) begin : g_level
      logic irq_q;
      assign o_irq[g] = irq_q;

      if (FILTER_CYCLES == 0) begin : g_nofilt
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) irq_q <= 1'b0;
          else          irq_q <= samp;
        end
      end else begin : g_filt
        localparam int CW = $clog2(FILTER_CYCLES + 1);
        logic [CW-1:0] cnt;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            cnt   <= '0;
            irq_q <= 1'b0;
          end else if (!i_irq_enable[g]) begin
            cnt   <= '0;
            irq_q <= 1'b0;
          end else if (samp == irq_q) begin
            cnt <= '0;
          end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
            cnt   <= '0;
            irq_q <= samp;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

`ifdef APU_IRQ_COND_DROP_EN
      logic unused_clr;
      assign unused_clr       = i_drop_clear[g];
      assign o_drop_sticky[g] = 1'b0;
`endif
    end else begin : g_pulse
      logic          s_q;
      logic          pend;
      logic          irq_q;
      logic [1:0]    state;
      logic [SW-1:0] scnt;
      logic          rise;
      logic          drop;

      assign rise     = samp & ~s_q;
      // A rise finding the single pending slot already full is lost, in any state.
      assign drop     = rise & pend;
      assign o_irq[g] = irq_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s_q   <= 1'b0;
          pend  <= 1'b0;
          irq_q <= 1'b0;
          state <= ST_IDLE;
          scnt  <= '0;
        end else begin
          s_q <= samp;
          if (!i_irq_enable[g]) begin
            pend  <= 1'b0;
            irq_q <= 1'b0;
            state <= ST_IDLE;
            scnt  <= '0;
          end else begin
            case (state)
              ST_IDLE: begin
                if (rise) begin
                  state <= ST_STRETCH;
                  irq_q <= 1'b1;
                  scnt  <= SW'(STRETCH_CYCLES - 1);
                end
              end
              ST_STRETCH: begin
                if (scnt == '0) begin
                  state <= ST_GAP;
                  irq_q <= 1'b0;
                end else begin
                  scnt <= scnt - 1'b1;
                end
                if (rise) pend <= 1'b1;
              end
              ST_GAP: begin
                // One low cycle so the PLIC gateway sees a fresh rising edge.
                if (pend || rise) begin
                  state <= ST_STRETCH;
                  irq_q <= 1'b1;
                  scnt  <= SW'(STRETCH_CYCLES - 1);
                  pend  <= 1'b0;
                end else begin
                  state <= ST_IDLE;
                end
              end
              default: begin
                state <= ST_IDLE;
                irq_q <= 1'b0;
              end
            endcase
          end
        end
      end

`ifdef APU_IRQ_COND_DROP_EN
      logic sticky_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sticky_q <= 1'b0;
        else          sticky_q <= (sticky_q & ~i_drop_clear[g]) | drop;
      end
      assign o_drop_sticky[g] = sticky_q;
`else
      logic unused_drop;
      assign unused_drop = drop;
`endif
    end
  end

endmodule

// File: tb/tb_apu_irq_conditioner.sv
// Self-checking bench for apu_irq_conditioner: directed scenarios plus random traffic against a behavioural model.
module tb_apu_irq_conditioner;

  localparam int N    = 6;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int STR  = 2;
  // src1 sync level, src2 async level, src3 sync pulse, src4 async pulse, src5 sync level, src6 sync pulse
  localparam logic [N:1] AMASK = 6'b001010;
  localparam logic [N:1] PMASK = 6'b101100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N:1]   raw = '0;
  logic [N:1]   en = '0;
  logic [N:1]   clr = '0;
  logic [N:1]   irq;
`ifdef APU_IRQ_COND_DROP_EN
  logic [N:1]   sticky;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apu_irq_conditioner #(
    .NUM_IRQ(N), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .STRETCH_CYCLES(STR),
    .ASYNC_MASK(AMASK), .PULSE_MASK(PMASK)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq_raw(raw), .i_irq_enable(en), .o_irq(irq)
`ifdef APU_IRQ_COND_DROP_EN
    , .o_drop_sticky(sticky), .i_drop_clear(clr)
`endif
  );

  // ---------------- behavioural reference model ----------------
  logic [N:1] m_irq;
  logic [N:1] m_stick;
  logic [N:1] s_hist[$];          // last FILT sampled (enabled) values
  bit         m_dly[1:N][0:SYNC-1];
  int         m_hi[1:N];          // remaining high cycles of current stretch
  bit         m_gap[1:N];
  bit         m_pend[1:N];
  bit         m_sprev[1:N];

  task automatic model_reset();
    m_irq   = '0;
    m_stick = '0;
    s_hist.delete();
    for (int i = 1; i <= N; i++) begin
      for (int k = 0; k < SYNC; k++) m_dly[i][k] = 1'b0;
      m_hi[i] = 0; m_gap[i] = 1'b0; m_pend[i] = 1'b0; m_sprev[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [N:1] s;
    bit all_mis, rise, drop;
    s = '0;
    for (int i = 1; i <= N; i++) begin
      if (AMASK[i]) begin
        s[i] = m_dly[i][SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) m_dly[i][k] = m_dly[i][k-1];
        m_dly[i][0] = raw[i];
      end else begin
        s[i] = raw[i];
      end
      s[i] = s[i] & en[i];
    end
    s_hist.push_back(s);
    if (s_hist.size() > FILT) void'(s_hist.pop_front());
    for (int i = 1; i <= N; i++) begin
      if (!PMASK[i]) begin
        // Output follows s once the last FILT samples all disagree with it.
        if (!en[i]) m_irq[i] = 1'b0;
        else if (s_hist.size() == FILT) begin
          all_mis = 1'b1;
          foreach (s_hist[k]) if (s_hist[k][i] == m_irq[i]) all_mis = 1'b0;
          if (all_mis) m_irq[i] = s[i];
        end
      end else begin
        rise = s[i] & ~m_sprev[i];
        m_sprev[i] = s[i];
        drop = 1'b0;
        if (!en[i]) begin
          m_hi[i] = 0; m_gap[i] = 1'b0; m_pend[i] = 1'b0;
        end else if (m_hi[i] > 0) begin
          m_hi[i] = m_hi[i] - 1;
          if (m_hi[i] == 0) m_gap[i] = 1'b1;
          if (rise) begin
            if (m_pend[i]) drop = 1'b1;
            else m_pend[i] = 1'b1;
          end
        end else if (m_gap[i]) begin
          m_gap[i] = 1'b0;
          if (rise && m_pend[i]) drop = 1'b1;
          if (rise || m_pend[i]) begin
            m_pend[i] = 1'b0;
            m_hi[i] = STR;
          end
        end else if (rise) begin
          m_hi[i] = STR;
        end
        m_irq[i]   = (m_hi[i] > 0);
        m_stick[i] = (m_stick[i] & ~clr[i]) | drop;
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (irq !== '0) begin
      failures++; $display("FAIL reset_irq: got=%b want=%b", irq, {N{1'b0}});
    end
`ifdef APU_IRQ_COND_DROP_EN
    checks++;
    if (sticky !== '0) begin
      failures++; $display("FAIL reset_sticky: got=%b want=%b", sticky, {N{1'b0}});
    end
`endif
  endtask

  task automatic test_level_sync();
    raw[1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      clk_step();
      checks++;
      if (irq[1] !== 1'b0 || irq !== m_irq) begin
        failures++; $display("FAIL level_short_high k=%0d: got=%b want=%b", k, irq, m_irq);
      end
    end
    raw[1] = 1'b0;
    repeat (4) clk_step();
    raw[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      checks++;
      if (irq[1] !== (k == 4) || irq !== m_irq) begin
        failures++; $display("FAIL level_rise k=%0d: got=%b want_bit=%b model=%b", k, irq, (k == 4), m_irq);
      end
    end
    raw[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      clk_step();
      checks++;
      if (irq[1] !== (k != 4) || irq !== m_irq) begin
        failures++; $display("FAIL level_fall k=%0d: got=%b want_bit=%b model=%b", k, irq, (k != 4), m_irq);
      end
    end
  endtask

  task automatic test_level_async();
    raw[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      clk_step();
      checks++;
      if (irq[2] !== (k == 6) || irq !== m_irq) begin
        failures++; $display("FAIL async_rise k=%0d: got=%b want_bit=%b model=%b", k, irq, (k == 6), m_irq);
      end
    end
    raw[2] = 1'b0;
    clk_step();
    raw[2] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      clk_step();
      checks++;
      if (irq[2] !== 1'b1 || irq !== m_irq) begin
        failures++; $display("FAIL async_glitch k=%0d: got=%b model=%b", k, irq, m_irq);
      end
    end
  endtask

  task automatic test_pulse();
    bit pat1[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit exp1[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit pat2[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit exp2[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      raw[3] = pat1[k];
      clk_step();
      checks++;
      if (irq[3] !== exp1[k] || irq !== m_irq) begin
        failures++; $display("FAIL pulse_single k=%0d: got=%b want_bit=%b model=%b", k, irq, exp1[k], m_irq);
      end
    end
    for (int k = 0; k < 7; k++) begin
      raw[3] = pat2[k];
      clk_step();
      checks++;
      if (irq[3] !== exp2[k] || irq !== m_irq) begin
        failures++; $display("FAIL pulse_pending k=%0d: got=%b want_bit=%b model=%b", k, irq, exp2[k], m_irq);
      end
    end
`ifdef APU_IRQ_COND_DROP_EN
    checks++;
    if (sticky[3] !== 1'b0) begin
      failures++; $display("FAIL pulse_no_drop: got=%b want=0", sticky[3]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit pat[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit exp[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      raw[3] = pat[k];
      clk_step();
      checks++;
      if (irq[3] !== exp[k] || irq !== m_irq) begin
        failures++; $display("FAIL burst k=%0d: got=%b want_bit=%b model=%b", k, irq, exp[k], m_irq);
      end
    end
`ifdef APU_IRQ_COND_DROP_EN
    checks++;
    if (sticky[3] !== 1'b1 || sticky !== m_stick) begin
      failures++; $display("FAIL drop_set: got=%b model=%b", sticky, m_stick);
    end
    clr[3] = 1'b1;
    clk_step();
    clr[3] = 1'b0;
    checks++;
    if (sticky[3] !== 1'b0 || sticky !== m_stick) begin
      failures++; $display("FAIL drop_clear: got=%b model=%b", sticky, m_stick);
    end
`endif
    repeat (3) clk_step();
  endtask

  task automatic test_enable();
    bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      raw[3] = pat[k];
      clk_step();
    end
    raw[3] = 1'b0;
    en[3]  = 1'b0;
    clk_step();
    checks++;
    if (irq[3] !== 1'b0 || irq !== m_irq) begin
      failures++; $display("FAIL disable_mid_stretch: got=%b model=%b", irq, m_irq);
    end
    repeat (2) clk_step();
    en[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      clk_step();
      checks++;
      if (irq[3] !== 1'b0 || irq !== m_irq) begin
        failures++; $display("FAIL reenable_quiet k=%0d: got=%b model=%b", k, irq, m_irq);
      end
    end
    raw[3] = 1'b1;
    clk_step();
    raw[3] = 1'b0;
    checks++;
    if (irq[3] !== 1'b1 || irq !== m_irq) begin
      failures++; $display("FAIL reenable_new_rise: got=%b model=%b", irq, m_irq);
    end
    repeat (4) clk_step();
  endtask

  task automatic test_reset_mid();
    bit exp[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    raw[1] = 1'b1;
    raw[2] = 1'b1;
    raw[3] = 1'b1;
    repeat (2) clk_step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (irq !== '0) begin
      failures++; $display("FAIL reset_async: got=%b want=%b", irq, {N{1'b0}});
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      clk_step();
      checks++;
      if (irq[3] !== exp[k] || irq !== m_irq) begin
        failures++; $display("FAIL reset_held_pulse k=%0d: got=%b want_bit=%b model=%b", k, irq, exp[k], m_irq);
      end
    end
    raw = '0;
    repeat (8) clk_step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int i = 1; i <= N; i++) begin
        if (PMASK[i]) raw[i] = ($urandom_range(0, 9) < 3);
        else if ($urandom_range(0, 4) == 0) raw[i] = ~raw[i];
        en[i]  = ($urandom_range(0, 39) != 0);
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      clk_step();
      checks++;
      if (irq !== m_irq) begin
        failures++; $display("FAIL random_irq cyc=%0d: got=%b model=%b", c, irq, m_irq);
      end
`ifdef APU_IRQ_COND_DROP_EN
      checks++;
      if (sticky !== m_stick) begin
        failures++; $display("FAIL random_sticky cyc=%0d: got=%b model=%b", c, sticky, m_stick);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #1 rst_n = 1'b1;
    en = '1;
    repeat (2) clk_step();
    test_level_sync();
    test_level_async();
    raw[2] = 1'b0;
    repeat (8) clk_step();
    test_pulse();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
